// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Sequencing controller for the 5-stage pipeline. Produces the load enables
// and bubble (synchronous clear) controls for the PC register and the
// F/D, D/X, X/M and M/W latches. It resolves three events, highest priority
// first:
//   1. mult/div occupancy of X (start pulse, freeze, watchdog abort)
//   2. taken branch / jump redirect resolved in X (kill D and F)
//   3. load-use hazard between the load in X and the instruction in D
//
// Parameters
//   MD_TIMEOUT  max cycles spent in MD_WAIT before the watchdog aborts (>= 2)
//   TMR_W       watchdog counter width, must be able to hold MD_TIMEOUT
//
// Ports
//   clk                      pipeline clock, rising edge
//   clr                      asynchronous reset, active low
//   fd_rs, fd_rt             source register fields of the instruction in D
//   fd_uses_rs, fd_uses_rt   D instruction actually reads rs / rt
//   dx_is_load, dx_rd        X instruction is a load, and its destination
//   dx_is_md                 X instruction is a mult/div
//   x_redirect               taken branch / jump resolved in X
//   md_ready                 mult/div result valid this cycle
//   pc_en .. mw_en           latch load enables
//   fd_clr, dx_clr, xm_clr   latch loads a NOP at the next edge
//   md_start                 one-cycle start pulse to the mult/div unit
//   md_busy                  controller is waiting on the mult/div unit
//   md_err                   sticky watchdog flag, cleared only by reset
//
// Optional feature (macro PIPE_PERF_CNT_EN)
//   Adds stall_cnt (cycles with pc_en=0) and flush_cnt (acted-on redirects),
//   both 16-bit saturating. Without the macro these ports do not exist and
//   the control behaviour is unchanged.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned TMR_W      = 7
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  fd_rs,
    input  logic [4:0]  fd_rt,
    input  logic        fd_uses_rs,
    input  logic        fd_uses_rt,
    input  logic        dx_is_load,
    input  logic [4:0]  dx_rd,
    input  logic        dx_is_md,
    input  logic        x_redirect,
    input  logic        md_ready,
    output logic        pc_en,
    output logic        fd_en,
    output logic        dx_en,
    output logic        xm_en,
    output logic        mw_en,
    output logic        fd_clr,
    output logic        dx_clr,
    output logic        xm_clr,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_e;

    // Last MD_WAIT cycle the watchdog tolerates before aborting.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             md_err_q, md_err_d;
    logic             load_use;

    // A register written by rd=$0 never creates a dependency: $0 is hardwired.
    assign load_use = dx_is_load && (dx_rd != 5'd0) &&
                      ((fd_uses_rs && (fd_rs == dx_rd)) ||
                       (fd_uses_rt && (fd_rt == dx_rd)));

    // NOTE: every output and next-state signal gets a default before the case
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        md_err_d = md_err_q;
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        dx_en    = 1'b1;
        xm_en    = 1'b1;
        mw_en    = 1'b1;
        fd_clr   = 1'b0;
        dx_clr   = 1'b0;
        xm_clr   = 1'b0;
        md_start = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (dx_is_md) begin
                    // Kick the unit and hold the mult/div in X; X/M gets
                    // bubbles until the result is ready. A redirect in the
                    // same cycle is dropped: md wins.
                    md_start = 1'b1;
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    dx_en    = 1'b0;
                    xm_clr   = 1'b1;
                    state_d  = ST_MD_WAIT;
                    timer_d  = '0;
                end else if (x_redirect) begin
                    // Kill the two younger instructions; PC loads the target.
                    fd_clr = 1'b1;
                    dx_clr = 1'b1;
                end else if (load_use) begin
                    // Hold PC and F/D one cycle, inject a bubble into X.
                    pc_en  = 1'b0;
                    fd_en  = 1'b0;
                    dx_clr = 1'b1;
                end
            end

            ST_MD_WAIT: begin
                if (md_ready) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                end else if (timer_q == TMR_LAST) begin
                    // Watchdog abort: release the pipeline but push a bubble
                    // into X/M since no valid result exists.
                    md_err_d = 1'b1;
                    xm_clr   = 1'b1;
                    state_d  = ST_RUN;
                    timer_d  = '0;
                end else begin
                    pc_en   = 1'b0;
                    fd_en   = 1'b0;
                    dx_en   = 1'b0;
                    xm_clr  = 1'b1;
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            default: begin
                state_d = ST_RUN;
                timer_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= ST_RUN;
            timer_q  <= '0;
            md_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            md_err_q <= md_err_d;
        end
    end

    assign md_busy = (state_q == ST_MD_WAIT);
    assign md_err  = md_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;
    logic        flush_act;

    // A redirect is acted on only in RUN and only when no mult/div overrides it.
    assign flush_act = (state_q == ST_RUN) && !dx_is_md && x_redirect;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (flush_act && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl. Directed scenarios cover reset,
// load-use stalls, redirect priority, mult/div handshake, watchdog abort and
// asynchronous reset; a randomized phase compares every cycle against a
// behavioural model of the sequencing rules. Inputs change 1 ns after the
// rising edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int unsigned TB_TIMEOUT = 6;
    localparam int unsigned TB_TMR_W   = 3;

    // Packed view of outputs: {pc,fd,dx,xm,mw en | fd,dx,xm clr | start,busy,err}
    localparam logic [10:0] IDLE_RUN  = 11'b11111_000_000;
    localparam logic [10:0] LU_STALL  = 11'b00111_010_000;
    localparam logic [10:0] REDIR     = 11'b11111_110_000;
    localparam logic [10:0] MD_KICK   = 11'b00011_001_100;
    localparam logic [10:0] MD_FROZEN = 11'b00011_001_010;
    localparam logic [10:0] MD_DONE   = 11'b11111_000_010;
    localparam logic [10:0] MD_ABORT  = 11'b11111_001_010;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [4:0] fd_rs, fd_rt, dx_rd;
    logic       fd_uses_rs, fd_uses_rt, dx_is_load, dx_is_md, x_redirect, md_ready;
    logic       pc_en, fd_en, dx_en, xm_en, mw_en;
    logic       fd_clr, dx_clr, xm_clr, md_start, md_busy, md_err;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit m_wait  = 1'b0;
    int m_cnt   = 0;   // cycles already spent waiting on mult/div
    bit m_err   = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    pipe_hazard_ctrl #(
        .MD_TIMEOUT (TB_TIMEOUT),
        .TMR_W      (TB_TMR_W)
    ) u_dut (
        .clk        (clk),
        .clr        (clr),
        .fd_rs      (fd_rs),
        .fd_rt      (fd_rt),
        .fd_uses_rs (fd_uses_rs),
        .fd_uses_rt (fd_uses_rt),
        .dx_is_load (dx_is_load),
        .dx_rd      (dx_rd),
        .dx_is_md   (dx_is_md),
        .x_redirect (x_redirect),
        .md_ready   (md_ready),
        .pc_en      (pc_en),
        .fd_en      (fd_en),
        .dx_en      (dx_en),
        .xm_en      (xm_en),
        .mw_en      (mw_en),
        .fd_clr     (fd_clr),
        .dx_clr     (dx_clr),
        .xm_clr     (xm_clr),
        .md_start   (md_start),
        .md_busy    (md_busy),
        .md_err     (md_err)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] observed();
        return {pc_en, fd_en, dx_en, xm_en, mw_en, fd_clr, dx_clr, xm_clr,
                md_start, md_busy, md_err};
    endfunction

    // Expected outputs for the current inputs, derived from the event rules.
    function automatic logic [10:0] model_out();
        logic pc = 1'b1, fd = 1'b1, dx = 1'b1;
        logic fdc = 1'b0, dxc = 1'b0, xmc = 1'b0, st = 1'b0;
        logic hz;
        hz = dx_is_load && (dx_rd != 0) &&
             ((fd_uses_rs && fd_rs == dx_rd) || (fd_uses_rt && fd_rt == dx_rd));
        if (m_wait) begin
            if (!md_ready) begin
                xmc = 1'b1;               // frozen or aborting: X/M gets a bubble
                if (m_cnt < int'(TB_TIMEOUT) - 1) begin
                    pc = 1'b0; fd = 1'b0; dx = 1'b0;
                end
            end
        end else if (dx_is_md) begin
            st = 1'b1; pc = 1'b0; fd = 1'b0; dx = 1'b0; xmc = 1'b1;
        end else if (x_redirect) begin
            fdc = 1'b1; dxc = 1'b1;
        end else if (hz) begin
            pc = 1'b0; fd = 1'b0; dxc = 1'b1;
        end
        return {pc, fd, dx, 1'b1, 1'b1, fdc, dxc, xmc, st, m_wait, m_err};
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_wait = 1'b0; m_cnt = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            logic [10:0] e;
            e = model_out();
            if (!e[10] && m_stall < 65535) m_stall++;
            if (!m_wait && !dx_is_md && x_redirect && m_flush < 65535) m_flush++;
            if (m_wait) begin
                if (md_ready) m_wait = 1'b0;
                else if (m_cnt == int'(TB_TIMEOUT) - 1) begin
                    m_wait = 1'b0; m_err = 1'b1;
                end else m_cnt++;
            end else if (dx_is_md) begin
                m_wait = 1'b1; m_cnt = 0;
            end
        end
    end

    task automatic set_idle();
        fd_rs = 5'd0; fd_rt = 5'd0; dx_rd = 5'd0;
        fd_uses_rs = 1'b0; fd_uses_rt = 1'b0; dx_is_load = 1'b0;
        dx_is_md = 1'b0; x_redirect = 1'b0; md_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        set_idle();
        repeat (2) @(negedge clk);
        #1 clr = 1'b1;
        step();
    endtask

    task automatic test_reset();
        set_idle();
        #3 clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (observed() !== IDLE_RUN) begin
            errors++;
            $display("FAIL reset_hold got=%b want=%b", observed(), IDLE_RUN);
        end
        #1 clr = 1'b1;
        @(negedge clk);
        checks++;
        if (observed() !== IDLE_RUN) begin
            errors++;
            $display("FAIL reset_release got=%b want=%b", observed(), IDLE_RUN);
        end
    endtask

    task automatic test_load_use();
        int stalls;
        // rs path: exactly one stall cycle, then the load has left X.
        step();
        fd_rs = 5'd5; fd_uses_rs = 1'b1; dx_is_load = 1'b1; dx_rd = 5'd5;
        @(negedge clk);
        checks++;
        if (observed() !== LU_STALL) begin
            errors++;
            $display("FAIL lu_rs_stall got=%b want=%b", observed(), LU_STALL);
        end
        stalls = (pc_en == 1'b0) ? 1 : 0;
        step();
        dx_is_load = 1'b0; dx_rd = 5'd0;   // bubble now in X, load in M
        repeat (2) begin
            @(negedge clk);
            if (pc_en == 1'b0) stalls++;
            step();
        end
        checks++;
        if (stalls !== 1) begin
            errors++;
            $display("FAIL lu_stall_count got=%0d want=1", stalls);
        end
        // rd=$0 never stalls.
        fd_rs = 5'd0; fd_uses_rs = 1'b1; dx_is_load = 1'b1; dx_rd = 5'd0;
        @(negedge clk);
        checks++;
        if (observed() !== IDLE_RUN) begin
            errors++;
            $display("FAIL lu_rd0 got=%b want=%b", observed(), IDLE_RUN);
        end
        // rt path stalls; same register but unused field does not.
        step();
        fd_uses_rs = 1'b0; fd_rt = 5'd7; fd_uses_rt = 1'b1; dx_rd = 5'd7;
        @(negedge clk);
        checks++;
        if (observed() !== LU_STALL) begin
            errors++;
            $display("FAIL lu_rt_stall got=%b want=%b", observed(), LU_STALL);
        end
        step();
        fd_uses_rt = 1'b0;
        @(negedge clk);
        checks++;
        if (observed() !== IDLE_RUN) begin
            errors++;
            $display("FAIL lu_rt_unused got=%b want=%b", observed(), IDLE_RUN);
        end
        step();
        set_idle();
    endtask

    task automatic test_redirect_priority();
        fd_rs = 5'd9; fd_uses_rs = 1'b1; dx_is_load = 1'b1; dx_rd = 5'd9;
        x_redirect = 1'b1;
        @(negedge clk);
        checks++;
        if (observed() !== REDIR) begin
            errors++;
            $display("FAIL redirect_over_lu got=%b want=%b", observed(), REDIR);
        end
        step();
        set_idle();  // killed instructions are bubbles now
        @(negedge clk);
        checks++;
        if (observed() !== IDLE_RUN) begin
            errors++;
            $display("FAIL redirect_no_stall got=%b want=%b", observed(), IDLE_RUN);
        end
        step();
    endtask

    task automatic test_md_ready();
        int frozen = 0;
        int starts = 0;
        dx_is_md = 1'b1;
        x_redirect = 1'b1;   // must be ignored under md
        for (int k = 0; k <= 5; k++) begin
            md_ready = (k == 5);
            @(negedge clk);
            if (pc_en == 1'b0) frozen++;
            if (md_start == 1'b1) starts++;
            if (k == 0) begin
                checks++;
                if (observed() !== MD_KICK) begin
                    errors++;
                    $display("FAIL md_kick got=%b want=%b", observed(), MD_KICK);
                end
            end else if (k == 5) begin
                checks++;
                if (observed() !== MD_DONE) begin
                    errors++;
                    $display("FAIL md_done got=%b want=%b", observed(), MD_DONE);
                end
            end else begin
                checks++;
                if (observed() !== MD_FROZEN) begin
                    errors++;
                    $display("FAIL md_frozen_k%0d got=%b want=%b", k, observed(), MD_FROZEN);
                end
            end
            step();
        end
        set_idle();
        @(negedge clk);
        checks++;
        if (observed() !== IDLE_RUN) begin
            errors++;
            $display("FAIL md_after got=%b want=%b", observed(), IDLE_RUN);
        end
        checks++;
        if (frozen !== 5 || starts !== 1) begin
            errors++;
            $display("FAIL md_counts got=frozen %0d starts %0d want=frozen 5 starts 1",
                     frozen, starts);
        end
        step();
    endtask

    task automatic test_md_timeout();
        int  frozen = 0;
        bit  released = 1'b0;
        dx_is_md = 1'b1;
        md_ready = 1'b0;
        for (int k = 0; k < 20 && !released; k++) begin
            @(negedge clk);
            if (pc_en == 1'b0) frozen++;
            else begin
                released = 1'b1;
                checks++;
                if (observed() !== MD_ABORT) begin
                    errors++;
                    $display("FAIL md_abort got=%b want=%b", observed(), MD_ABORT);
                end
            end
            step();
        end
        checks++;
        if (!released || frozen !== int'(TB_TIMEOUT)) begin
            errors++;
            $display("FAIL md_timeout_len got=released %0d frozen %0d want=released 1 frozen %0d",
                     released, frozen, TB_TIMEOUT);
        end
        set_idle();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (md_busy !== 1'b0 || md_err !== 1'b1) begin
                errors++;
                $display("FAIL md_err_sticky got=busy %b err %b want=busy 0 err 1",
                         md_busy, md_err);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        dx_is_md = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (md_busy !== 1'b1 || md_err !== m_err) begin
            errors++;
            $display("FAIL ar_pre got=busy %b err %b want=busy 1 err %b", md_busy, md_err, m_err);
        end
        #2 clr = 1'b0;
        #1;
        checks++;
        if (md_busy !== 1'b0 || md_err !== 1'b0) begin
            errors++;
            $display("FAIL ar_immediate got=busy %b err %b want=busy 0 err 0", md_busy, md_err);
        end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL ar_counters got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
        end
`endif
        set_idle();
        @(negedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        checks++;
        if (observed() !== IDLE_RUN) begin
            errors++;
            $display("FAIL ar_after got=%b want=%b", observed(), IDLE_RUN);
        end
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            fd_rs      = 5'($urandom_range(0, 3));
            fd_rt      = 5'($urandom_range(0, 3));
            dx_rd      = 5'($urandom_range(0, 3));
            fd_uses_rs = 1'($urandom_range(0, 1));
            fd_uses_rt = 1'($urandom_range(0, 1));
            dx_is_load = ($urandom_range(0, 2) == 0);
            dx_is_md   = ($urandom_range(0, 9) == 0);
            x_redirect = ($urandom_range(0, 5) == 0);
            md_ready   = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            checks++;
            if (observed() !== model_out()) begin
                errors++;
                $display("FAIL rand_c%0d got=%b want=%b", n, observed(), model_out());
            end
`ifdef PIPE_PERF_CNT_EN
            checks++;
            if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
                errors++;
                $display("FAIL rand_cnt_c%0d got=%0d/%0d want=%0d/%0d",
                         n, stall_cnt, flush_cnt, m_stall, m_flush);
            end
`endif
            step();
        end
        set_idle();
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        repeat (3) begin
            fd_rs = 5'd3; fd_uses_rs = 1'b1; dx_is_load = 1'b1; dx_rd = 5'd3;
            step();
            set_idle();
            step();
        end
        repeat (2) begin
            x_redirect = 1'b1;
            step();
            set_idle();
            step();
        end
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'd3 || flush_cnt !== 16'd2) begin
            errors++;
            $display("FAIL perf_counts got=%0d/%0d want=3/2", stall_cnt, flush_cnt);
        end
        fd_rs = 5'd3; fd_uses_rs = 1'b1; dx_is_load = 1'b1; dx_rd = 5'd3;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL perf_saturate got=%h want=ffff", stall_cnt);
        end
        set_idle();
    endtask
`endif

    initial begin
        set_idle();
        test_reset();
        test_load_use();
        test_redirect_priority();
        test_md_ready();
        test_md_timeout();
        test_async_reset();
        test_random();
`ifdef PIPE_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
